// File: rtl/wishbone_pkg.sv
// Shared Wishbone types for the bus master and the SRAM slave.
package wishbone_pkg;

   localparam int unsigned SEL_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACK
   } wb_slave_state_e;

   typedef enum logic [1:0] {
      M_IDLE,
      M_REQ,
      M_DONE
   } wb_master_state_e;

   typedef struct packed {
      logic             we;
      logic [SEL_W-1:0] sel;
      logic             tag;
   } wb_ctrl_t;

endpackage

// File: rtl/wb_sram_array.sv
// Single-port SRAM: synchronous read, per-byte write enable, no reset on contents.
module wb_sram_array
   import wishbone_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH  = 32,
   parameter  int unsigned DEPTH_WORDS = 1024,
   localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic                  clk,
   input  logic [IDX_W-1:0]      addr,
   input  logic                  we,
   input  logic [SEL_W-1:0]      be,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

   // Byte-lane write and read-before-write registered read of the addressed word.
   always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < SEL_W; k++) begin
         if (we && be[k]) begin
            mem[addr][8*k +: 8] <= wdata[8*k +: 8];
         end
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/wishbone_slave_sram.sv
// Wishbone classic slave fronting a byte-writable SRAM with programmable wait states.
module wishbone_slave_sram
   import wishbone_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int unsigned           DEPTH_WORDS = 1024,
   parameter int unsigned           WAIT_STATES = 0
) (
   input  logic                  i_CLK,
   input  logic                  i_RST,
   input  logic [ADDR_WIDTH-1:0] i_ADDR,
   input  logic [DATA_WIDTH-1:0] i_DATA,
   output logic [DATA_WIDTH-1:0] o_DATA,
   input  logic                  i_WE,
   input  logic [SEL_W-1:0]      i_SEL,
   input  logic                  i_STB,
   input  logic                  i_CYC,
   output logic                  o_ACK,
   input  logic                  i_TAGN,
   output logic                  o_TAGN
);

   localparam int unsigned         IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [ADDR_WIDTH:0] SPAN      = (ADDR_WIDTH+1)'(DEPTH_WORDS * 4);
   localparam logic [3:0]          LAST_WAIT = 4'(WAIT_STATES - 1);

   wb_slave_state_e       state, state_nx;
   logic [3:0]            wait_cnt;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [DATA_WIDTH-1:0] data_r;
   wb_ctrl_t              ctrl_r;

   logic                  accept;
   logic                  enter_ack;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [DATA_WIDTH-1:0] cur_data;
   logic                  cur_we;
   logic [SEL_W-1:0]      cur_sel;
   logic [ADDR_WIDTH-1:0] offset;
   logic                  in_range;
   logic [IDX_W-1:0]      word_idx;
   logic [DATA_WIDTH-1:0] rdata;

   assign accept = (state == ST_IDLE) && i_CYC && i_STB;

   // While IDLE the SRAM is driven from the live bus so a zero-wait transfer
   // can read/commit on the accept edge itself; afterwards the registered request is used.
   assign cur_addr = (state == ST_IDLE) ? i_ADDR : addr_r;
   assign cur_data = (state == ST_IDLE) ? i_DATA : data_r;
   assign cur_we   = (state == ST_IDLE) ? i_WE   : ctrl_r.we;
   assign cur_sel  = (state == ST_IDLE) ? i_SEL  : ctrl_r.sel;

   assign offset    = cur_addr - BASE_ADDR;
   assign in_range  = {1'b0, offset} < SPAN;
   assign word_idx  = offset[IDX_W+1:2];
   assign enter_ack = (state_nx == ST_ACK) && (state != ST_ACK);

   wb_sram_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_array (
      .clk  (i_CLK),
      .addr (word_idx),
      .we   (enter_ack && cur_we && in_range),
      .be   (cur_sel),
      .wdata(cur_data),
      .rdata(rdata)
   );

   // State register.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Wait-cycle counter: cleared on accept, counts each WAIT cycle.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         wait_cnt <= '0;
      end else if (accept) begin
         wait_cnt <= '0;
      end else if (state == ST_WAIT) begin
         wait_cnt <= wait_cnt + 4'd1;
      end
   end

   // Capture the request on the accept edge.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         addr_r <= '0;
         data_r <= '0;
         ctrl_r <= '0;
      end else if (accept) begin
         addr_r <= i_ADDR;
         data_r <= i_DATA;
         ctrl_r <= '{we: i_WE, sel: i_SEL, tag: i_TAGN};
      end
   end

   // Next-state logic and bus outputs.
   always_comb begin
      state_nx = state;
      o_ACK    = 1'b0;
      o_DATA   = '0;
      o_TAGN   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_CYC && i_STB) begin
               state_nx = (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!i_CYC) begin
               state_nx = ST_IDLE;
            end else if (wait_cnt == LAST_WAIT) begin
               state_nx = ST_ACK;
            end
         end
         ST_ACK: begin
            state_nx = ST_IDLE;
            o_ACK    = 1'b1;
            o_TAGN   = ctrl_r.tag;
            if (!ctrl_r.we && in_range) begin
               o_DATA = rdata;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_wishbone_slave_sram.sv
// Self-checking bench: three slave configurations against a word-array reference model.
module tb_wishbone_slave_sram;

   logic        clk = 1'b0;
   logic        rst  [3];
   logic        cyc  [3];
   logic        stb  [3];
   logic        we_s [3];
   logic        tag  [3];
   logic        ack  [3];
   logic        otag [3];
   logic [31:0] addr [3];
   logic [31:0] wdat [3];
   logic [31:0] odat [3];
   logic [3:0]  sel  [3];

   int tests = 0;
   int fails = 0;

   logic [31:0] mdl [3][1024];

   always #5 clk = ~clk;

   wishbone_slave_sram #(.WAIT_STATES(0)) u0 (
      .i_CLK(clk), .i_RST(rst[0]), .i_ADDR(addr[0]), .i_DATA(wdat[0]), .o_DATA(odat[0]),
      .i_WE(we_s[0]), .i_SEL(sel[0]), .i_STB(stb[0]), .i_CYC(cyc[0]), .o_ACK(ack[0]),
      .i_TAGN(tag[0]), .o_TAGN(otag[0]));

   wishbone_slave_sram #(.DEPTH_WORDS(16), .WAIT_STATES(3)) u1 (
      .i_CLK(clk), .i_RST(rst[1]), .i_ADDR(addr[1]), .i_DATA(wdat[1]), .o_DATA(odat[1]),
      .i_WE(we_s[1]), .i_SEL(sel[1]), .i_STB(stb[1]), .i_CYC(cyc[1]), .o_ACK(ack[1]),
      .i_TAGN(tag[1]), .o_TAGN(otag[1]));

   wishbone_slave_sram #(.BASE_ADDR(32'h1000_0000), .DEPTH_WORDS(1024), .WAIT_STATES(1)) u2 (
      .i_CLK(clk), .i_RST(rst[2]), .i_ADDR(addr[2]), .i_DATA(wdat[2]), .o_DATA(odat[2]),
      .i_WE(we_s[2]), .i_SEL(sel[2]), .i_STB(stb[2]), .i_CYC(cyc[2]), .o_ACK(ack[2]),
      .i_TAGN(tag[2]), .o_TAGN(otag[2]));

   function automatic logic [31:0] base_of(input int u);
      return (u == 2) ? 32'h1000_0000 : 32'h0;
   endfunction

   function automatic int dep_of(input int u);
      return (u == 1) ? 16 : 1024;
   endfunction

   function automatic int ws_of(input int u);
      return (u == 0) ? 0 : (u == 1) ? 3 : 1;
   endfunction

   function automatic bit m_in(input int u, input logic [31:0] a);
      logic [31:0] off;
      off = a - base_of(u);
      return off < 32'(dep_of(u) * 4);
   endfunction

   function automatic int m_idx(input int u, input logic [31:0] a);
      logic [31:0] off;
      off = a - base_of(u);
      return int'(off >> 2);
   endfunction

   function automatic logic [31:0] m_read(input int u, input logic [31:0] a);
      return m_in(u, a) ? mdl[u][m_idx(u, a)] : 32'h0;
   endfunction

   task automatic m_write(input int u, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      if (m_in(u, a)) begin
         for (int k = 0; k < 4; k++) begin
            if (s[k]) mdl[u][m_idx(u, a)][8*k +: 8] = d[8*k +: 8];
         end
      end
   endtask

   // Bus driver: holds CYC/STB until ACK and one edge beyond, recording latency
   // (accept edge counts as 1), data/tag seen in ACK, and any output activity outside ACK.
   task automatic xfer(input int u, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic t, output int lat,
                       output logic [31:0] rd, output logic tg, output bit leak);
      @(negedge clk);
      cyc[u] = 1'b1; stb[u] = 1'b1; we_s[u] = w; addr[u] = a; wdat[u] = d; sel[u] = s; tag[u] = t;
      lat = -1; rd = '0; tg = 1'b0; leak = 1'b0;
      for (int n = 1; n <= 40 && lat < 0; n++) begin
         @(posedge clk); #1;
         if (ack[u] === 1'b1) begin
            lat = n; rd = odat[u]; tg = otag[u];
         end else if (odat[u] !== 32'h0 || otag[u] !== 1'b0 || ack[u] !== 1'b0) begin
            leak = 1'b1;
         end
      end
      if (lat >= 0) begin
         @(posedge clk); #1;
         if (ack[u] !== 1'b0 || odat[u] !== 32'h0 || otag[u] !== 1'b0) leak = 1'b1;
      end
      cyc[u] = 1'b0; stb[u] = 1'b0; we_s[u] = 1'b0; tag[u] = 1'b0;
      addr[u] = $urandom; wdat[u] = $urandom; sel[u] = 4'($urandom_range(0, 15));
   endtask

   task automatic test_reset();
      for (int u = 0; u < 3; u++) begin
         rst[u] = 1'b1; cyc[u] = 1'b1; stb[u] = 1'b1; we_s[u] = 1'b0; tag[u] = 1'b1;
         addr[u] = '0; wdat[u] = '0; sel[u] = 4'hF;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int u = 0; u < 3; u++) begin
         tests++;
         if (ack[u] !== 1'b0) begin fails++; $display("FAIL reset_ack[%0d]: got %b expected 0", u, ack[u]); end
         tests++;
         if (odat[u] !== 32'h0) begin fails++; $display("FAIL reset_data[%0d]: got %h expected 0", u, odat[u]); end
         tests++;
         if (otag[u] !== 1'b0) begin fails++; $display("FAIL reset_tag[%0d]: got %b expected 0", u, otag[u]); end
      end
      @(negedge clk);
      for (int u = 0; u < 3; u++) begin
         cyc[u] = 1'b0; stb[u] = 1'b0; tag[u] = 1'b0; rst[u] = 1'b0;
      end
   endtask

   task automatic test_basic();
      int lat; logic [31:0] rd; logic tg; bit leak;
      xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, lat, rd, tg, leak);
      m_write(0, 32'h10, 32'hDEADBEEF, 4'hF);
      tests++;
      if (lat !== 1) begin fails++; $display("FAIL basic_wr_lat: got %0d expected 1", lat); end
      tests++;
      if (rd !== 32'h0 || leak) begin fails++; $display("FAIL basic_wr_bus: data %h leak %b expected 0/0", rd, leak); end
      xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, lat, rd, tg, leak);
      tests++;
      if (lat !== 1) begin fails++; $display("FAIL basic_rd_lat: got %0d expected 1", lat); end
      tests++;
      if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL basic_rd_data: got %h expected deadbeef", rd); end
      tests++;
      if (leak) begin fails++; $display("FAIL basic_rd_leak: got 1 expected 0"); end
   endtask

   task automatic test_byte_lanes();
      int lat; logic [31:0] rd; logic tg; bit leak;
      xfer(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b0, lat, rd, tg, leak);
      m_write(0, 32'h10, 32'h11223344, 4'b0101);
      xfer(0, 1'b0, 32'h13, 32'h0, 4'b0000, 1'b0, lat, rd, tg, leak);
      tests++;
      if (rd !== 32'hDE22BE44) begin fails++; $display("FAIL lanes_data: got %h expected de22be44", rd); end
   endtask

   task automatic test_wait_states();
      int lat; logic [31:0] rd; logic tg; bit leak;
      xfer(1, 1'b1, 32'h8, 32'h5A5A1234, 4'hF, 1'b0, lat, rd, tg, leak);
      m_write(1, 32'h8, 32'h5A5A1234, 4'hF);
      tests++;
      if (lat !== 4) begin fails++; $display("FAIL ws_wr_lat: got %0d expected 4", lat); end
      xfer(1, 1'b0, 32'h8, 32'h0, 4'h1, 1'b0, lat, rd, tg, leak);
      tests++;
      if (lat !== 4) begin fails++; $display("FAIL ws_rd_lat: got %0d expected 4", lat); end
      tests++;
      if (rd !== m_read(1, 32'h8)) begin fails++; $display("FAIL ws_rd_data: got %h expected %h", rd, m_read(1, 32'h8)); end
      tests++;
      if (leak) begin fails++; $display("FAIL ws_rd_leak: got 1 expected 0"); end
   endtask

   task automatic test_out_of_range();
      int lat; logic [31:0] rd; logic tg; bit leak;
      xfer(2, 1'b1, 32'h1000_0000, 32'hCAFEF00D, 4'hF, 1'b0, lat, rd, tg, leak);
      m_write(2, 32'h1000_0000, 32'hCAFEF00D, 4'hF);
      xfer(2, 1'b1, 32'h1000_0FFC, 32'h0BADF00D, 4'hF, 1'b0, lat, rd, tg, leak);
      m_write(2, 32'h1000_0FFC, 32'h0BADF00D, 4'hF);
      xfer(2, 1'b1, 32'h1000_1000, 32'h55555555, 4'hF, 1'b0, lat, rd, tg, leak);
      m_write(2, 32'h1000_1000, 32'h55555555, 4'hF);
      tests++;
      if (lat !== 2) begin fails++; $display("FAIL oor_wr_lat: got %0d expected 2", lat); end
      xfer(2, 1'b0, 32'h1000_1000, 32'h0, 4'hF, 1'b0, lat, rd, tg, leak);
      tests++;
      if (lat !== 2) begin fails++; $display("FAIL oor_rd_lat: got %0d expected 2", lat); end
      tests++;
      if (rd !== 32'h0) begin fails++; $display("FAIL oor_rd_data: got %h expected 0", rd); end
      xfer(2, 1'b0, 32'h1000_0003, 32'h0, 4'h0, 1'b0, lat, rd, tg, leak);
      tests++;
      if (rd !== m_read(2, 32'h1000_0000)) begin fails++; $display("FAIL oor_word0: got %h expected %h", rd, m_read(2, 32'h1000_0000)); end
      xfer(2, 1'b0, 32'h1000_0FFC, 32'h0, 4'h0, 1'b0, lat, rd, tg, leak);
      tests++;
      if (rd !== 32'h0BADF00D) begin fails++; $display("FAIL oor_lastword: got %h expected 0badf00d", rd); end
   endtask

   task automatic test_abort();
      int lat; logic [31:0] rd; logic tg; bit leak; bit seen;
      xfer(1, 1'b1, 32'h20, 32'h12345678, 4'hF, 1'b0, lat, rd, tg, leak);
      m_write(1, 32'h20, 32'h12345678, 4'hF);
      @(negedge clk);
      cyc[1] = 1'b1; stb[1] = 1'b1; we_s[1] = 1'b1; addr[1] = 32'h20; wdat[1] = 32'hAAAAAAAA; sel[1] = 4'hF;
      seen = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         if (ack[1] !== 1'b0) seen = 1'b1;
      end
      cyc[1] = 1'b0; stb[1] = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (ack[1] !== 1'b0) seen = 1'b1;
      end
      we_s[1] = 1'b0;
      tests++;
      if (seen) begin fails++; $display("FAIL abort_ack: got ack expected none"); end
      xfer(1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, lat, rd, tg, leak);
      tests++;
      if (rd !== m_read(1, 32'h20)) begin fails++; $display("FAIL abort_data: got %h expected %h", rd, m_read(1, 32'h20)); end
   endtask

   task automatic test_reset_mid();
      int lat; logic [31:0] rd; logic tg; bit leak;
      xfer(1, 1'b1, 32'h24, 32'h13572468, 4'hF, 1'b0, lat, rd, tg, leak);
      m_write(1, 32'h24, 32'h13572468, 4'hF);
      @(negedge clk);
      cyc[1] = 1'b1; stb[1] = 1'b1; we_s[1] = 1'b1; addr[1] = 32'h24; wdat[1] = 32'hAAAAAAAA; sel[1] = 4'hF; tag[1] = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst[1] = 1'b1;
      #1;
      tests++;
      if (ack[1] !== 1'b0 || odat[1] !== 32'h0 || otag[1] !== 1'b0) begin
         fails++; $display("FAIL rst_wait_out: ack %b data %h tag %b expected 0/0/0", ack[1], odat[1], otag[1]);
      end
      @(negedge clk);
      cyc[1] = 1'b0; stb[1] = 1'b0; we_s[1] = 1'b0; tag[1] = 1'b0;
      @(negedge clk);
      rst[1] = 1'b0;
      xfer(1, 1'b0, 32'h24, 32'h0, 4'hF, 1'b0, lat, rd, tg, leak);
      tests++;
      if (rd !== 32'h13572468) begin fails++; $display("FAIL rst_nowrite: got %h expected 13572468", rd); end
      xfer(1, 1'b0, 32'h24, 32'h0, 4'hF, 1'b1, lat, rd, tg, leak);
      tests++;
      if (tg !== 1'b1) begin fails++; $display("FAIL tag_in_ack: got %b expected 1", tg); end
      tests++;
      if (leak) begin fails++; $display("FAIL tag_outside_ack: got leak expected none"); end
      // Reset landing inside the ACK cycle must clear the outputs asynchronously.
      @(negedge clk);
      cyc[1] = 1'b1; stb[1] = 1'b1; we_s[1] = 1'b0; addr[1] = 32'h24; tag[1] = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      tests++;
      if (ack[1] !== 1'b1 || odat[1] !== 32'h13572468) begin
         fails++; $display("FAIL rst_ack_pre: ack %b data %h expected 1/13572468", ack[1], odat[1]);
      end
      rst[1] = 1'b1;
      #1;
      tests++;
      if (ack[1] !== 1'b0 || odat[1] !== 32'h0 || otag[1] !== 1'b0) begin
         fails++; $display("FAIL rst_ack_out: ack %b data %h tag %b expected 0/0/0", ack[1], odat[1], otag[1]);
      end
      @(negedge clk);
      cyc[1] = 1'b0; stb[1] = 1'b0; tag[1] = 1'b0;
      @(negedge clk);
      rst[1] = 1'b0;
   endtask

   task automatic test_back_to_back();
      int p;
      bit exp_ack;
      for (int u = 0; u < 2; u++) begin
         p = ws_of(u) + 2;
         @(negedge clk);
         cyc[u] = 1'b1; stb[u] = 1'b1; we_s[u] = 1'b0; addr[u] = 32'h10 + 32'(u) * 32'h10; tag[u] = 1'b0;
         for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            exp_ack = (n % p) == (p - 1);
            tests++;
            if (ack[u] !== exp_ack) begin
               fails++; $display("FAIL b2b_ack[%0d] edge %0d: got %b expected %b", u, n, ack[u], exp_ack);
            end else if (exp_ack && odat[u] !== m_read(u, addr[u])) begin
               fails++; $display("FAIL b2b_data[%0d]: got %h expected %h", u, odat[u], m_read(u, addr[u]));
            end
         end
         cyc[u] = 1'b0; stb[u] = 1'b0;
      end
   endtask

   task automatic test_random();
      int lat; logic [31:0] rd; logic tg; bit leak;
      int u; bit w; logic [31:0] a; logic [31:0] d; logic [3:0] s; logic t; logic [31:0] exp_rd;
      for (int v = 0; v < 3; v++) begin
         for (int k = 0; k < 20; k++) begin
            a = base_of(v) + 32'(k) * 4;
            d = $urandom;
            xfer(v, 1'b1, a, d, 4'hF, 1'b0, lat, rd, tg, leak);
            m_write(v, a, d, 4'hF);
            tests++;
            if (lat !== ws_of(v) + 1) begin fails++; $display("FAIL fill_lat[%0d]: got %0d expected %0d", v, lat, ws_of(v) + 1); end
         end
      end
      for (int i = 0; i < 40; i++) begin
         u = int'($urandom_range(0, 2));
         w = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) a = base_of(u) - 32'd4;
         else a = base_of(u) + $urandom_range(0, 19) * 4 + $urandom_range(0, 3);
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         t = 1'($urandom_range(0, 1));
         exp_rd = w ? 32'h0 : m_read(u, a);
         xfer(u, w, a, d, s, t, lat, rd, tg, leak);
         if (w) m_write(u, a, d, s);
         tests++;
         if (lat !== ws_of(u) + 1) begin fails++; $display("FAIL rnd_lat[%0d] u%0d: got %0d expected %0d", i, u, lat, ws_of(u) + 1); end
         tests++;
         if (rd !== exp_rd) begin fails++; $display("FAIL rnd_data[%0d] u%0d a=%h: got %h expected %h", i, u, a, rd, exp_rd); end
         tests++;
         if (tg !== t || leak) begin fails++; $display("FAIL rnd_tag[%0d] u%0d: tag %b leak %b expected %b/0", i, u, tg, leak, t); end
      end
   endtask

   initial begin
      for (int u = 0; u < 3; u++) begin
         rst[u] = 1'b1; cyc[u] = 1'b0; stb[u] = 1'b0; we_s[u] = 1'b0; tag[u] = 1'b0;
         addr[u] = '0; wdat[u] = '0; sel[u] = '0;
      end
      test_reset();
      test_basic();
      test_byte_lanes();
      test_wait_states();
      test_out_of_range();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/wishbone_slave_sram.md
WISHBONE_SLAVE_SRAM -- requirements
Module: wishbone_slave_sram

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, bus data width; ADDR_WIDTH, default 32, bus byte-address width; BASE_ADDR, default 0, byte base address; DEPTH_WORDS, default 1024, power-of-two storage words; WAIT_STATES, default 0, range 0..15, extra cycles before ACK.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- i_CLK  in  1  single clock; all state on rising edge.
- i_RST  in  1  asynchronous, active-high reset.
- i_ADDR  in  ADDR_WIDTH  byte address.
- i_DATA  in  DATA_WIDTH  write data.
- o_DATA  out  DATA_WIDTH  read data.
- i_WE  in  1  1 = write, 0 = read.
- i_SEL  in  4  byte-lane enables.
- i_STB  in  1  strobe.
- i_CYC  in  1  cycle valid.
- o_ACK  out  1  transfer-complete pulse.
- i_TAGN  in  1  request tag.
- o_TAGN  out  1  response tag.

Function
REQ-003 A request SHALL be accepted in IDLE on a rising edge where i_CYC=1 and i_STB=1; i_ADDR, i_DATA, i_WE, i_SEL and i_TAGN SHALL be registered at that edge.
REQ-004 The FSM SHALL have states IDLE, WAIT and ACK: IDLE->ACK on accept when WAIT_STATES=0; IDLE->WAIT on accept otherwise; WAIT->ACK when the wait counter reaches WAIT_STATES-1; ACK->IDLE unconditionally; WAIT->IDLE if i_CYC=0 (abort).
REQ-005 The wait counter SHALL be 4 bits, SHALL clear on accept, and SHALL increment by one per WAIT cycle.
REQ-006 o_ACK SHALL be 1 for exactly one cycle, in state ACK only, i.e. the cycle that starts WAIT_STATES+1 edges after the accept edge.
REQ-007 The block SHALL be in range when (ADDR - BASE_ADDR) < DEPTH_WORDS*4 (unsigned, ADDR_WIDTH bits); word index SHALL be that offset[log2(DEPTH_WORDS)+1:2]; ADDR[1:0] SHALL be ignored.
REQ-008 An in-range write SHALL update, at the edge entering ACK, only the bytes whose SEL bit is 1 (SEL[k] -> DATA[8k+7:8k]); other bytes SHALL be unchanged.
REQ-009 An in-range read SHALL drive the full stored word on o_DATA during the ACK cycle, regardless of SEL.
REQ-010 An out-of-range access SHALL still be acknowledged per REQ-006; an out-of-range write SHALL modify nothing; an out-of-range read SHALL return 0.
REQ-011 o_DATA SHALL be 0 in every cycle other than the ACK cycle of a read.
REQ-012 o_TAGN SHALL equal the registered i_TAGN during the ACK cycle and SHALL be 0 otherwise.
REQ-013 An abort (i_CYC=0 in WAIT) SHALL produce no ACK and no write, and SHALL return the FSM to IDLE.
REQ-014 i_STB/i_CYC high in the ACK cycle SHALL be ignored; a new request SHALL be accepted only from IDLE, so back-to-back transfers have at least one IDLE cycle between ACKs.

Reset
REQ-015 Asserting i_RST at any time SHALL immediately force: state IDLE, counter 0, o_ACK=0, o_DATA=0, o_TAGN=0, and all request registers cleared.
REQ-016 Reset asserted during WAIT or ACK SHALL cancel the transfer, with no write committed if reset precedes the ACK edge; storage contents SHALL NOT be reset.

Structure
REQ-017 The state enum (IDLE, WAIT, ACK) and the SEL width constant (4) SHALL live in the shared package wishbone_pkg, alongside the master's types.
REQ-018 Storage SHALL be a sub-module wb_sram_array: single port, synchronous read, per-byte write enable, DEPTH_WORDS x DATA_WIDTH.

Verification
REQ-019 Test: WAIT_STATES=0, write 0xDEADBEEF to 0x0000_0010 with SEL=1111, then read it back -> each ACK rises exactly one cycle after STB is first sampled, and the read returns 0xDEADBEEF.
REQ-020 Test: over stored 0xDEADBEEF, write 0x11223344 with SEL=0101, then read -> 0xDE22BE44.
REQ-021 Test: WAIT_STATES=3, read -> ACK arrives 4 edges after accept, is 1 cycle wide, and o_DATA=0 outside ACK.
REQ-022 Test: BASE_ADDR=0x1000_0000, DEPTH_WORDS=1024; write to 0x1000_1000, then read it -> ACK given, data 0, and word 0 unchanged.
REQ-023 Test: WAIT_STATES=3; drop CYC in the 2nd WAIT cycle of a write of 0xAAAAAAAA -> no ACK, and a later read returns the old value.
REQ-024 Test: assert i_RST mid-WAIT -> o_ACK, o_DATA, o_TAGN are 0 immediately, with no write; i_TAGN=1 on the next transfer gives o_TAGN=1 only in its ACK cycle.
